// File: rtl/lr_shared_divider_arbiter.sv
// Sequential restoring divider shared by two requesters (theta0 / theta1 of the
// linear regression estimator). Round-robin grant, req/ack handshake, one
// DATA_WIDTH-cycle divide per grant, signed operands, quotient truncated toward zero.
module lr_shared_divider_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_req0,
    input  logic [DATA_WIDTH-1:0] i_dividend0,
    input  logic [DATA_WIDTH-1:0] i_divisor0,
    output logic                  o_ack0,
    output logic                  o_vld0,
    input  logic                  i_req1,
    input  logic [DATA_WIDTH-1:0] i_dividend1,
    input  logic [DATA_WIDTH-1:0] i_divisor1,
    output logic                  o_ack1,
    output logic                  o_vld1,
    output logic [DATA_WIDTH-1:0] o_quot,
    output logic [DATA_WIDTH-1:0] o_rem,
    output logic                  o_div_zero,
    output logic                  o_busy
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t                state;
    logic                  ptr;        // requester favoured when both ask
    logic                  owner;      // requester being served
    logic                  q_neg;      // quotient sign
    logic                  r_neg;      // remainder sign (sign of dividend)
    logic                  zero_div;   // latched divisor was zero
    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] q_reg;      // dividend bits shift out, quotient bits shift in
    logic [DATA_WIDTH-1:0] r_reg;      // partial remainder, always < |divisor|
    logic [DATA_WIDTH-1:0] d_reg;      // |divisor|, unsigned, at most 2^(W-1)

    logic                  any_req;
    logic                  winner;
    logic                  grant;
    logic [DATA_WIDTH-1:0] sel_dvd;
    logic [DATA_WIDTH-1:0] sel_dvs;
    logic [DATA_WIDTH:0]   dvd_ext;
    logic [DATA_WIDTH:0]   dvs_ext;
    logic [DATA_WIDTH-1:0] dvd_mag;
    logic [DATA_WIDTH-1:0] dvs_mag;

    // Arbitration and operand magnitude extraction for the candidate grant
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        any_req = i_req0 | i_req1;
        winner  = (i_req0 && i_req1) ? ptr : i_req1;
        grant   = any_req && (state == IDLE || state == DONE);
        sel_dvd = winner ? i_dividend1 : i_dividend0;
        sel_dvs = winner ? i_divisor1  : i_divisor0;
        // Sign-extend by one bit so -2^(W-1) negates to +2^(W-1) exactly;
        // that magnitude still fits a W-bit unsigned value.
        dvd_ext = {sel_dvd[DATA_WIDTH-1], sel_dvd};
        dvs_ext = {sel_dvs[DATA_WIDTH-1], sel_dvs};
        dvd_mag = DATA_WIDTH'(sel_dvd[DATA_WIDTH-1] ? -dvd_ext : dvd_ext);
        dvs_mag = DATA_WIDTH'(sel_dvs[DATA_WIDTH-1] ? -dvs_ext : dvs_ext);
    end

    logic [DATA_WIDTH:0]   r_shift;
    logic [DATA_WIDTH:0]   d_ext;
    logic                  fits;
    logic [DATA_WIDTH-1:0] r_step;
    logic [DATA_WIDTH-1:0] q_step;
    logic [DATA_WIDTH-1:0] q_fix;
    logic [DATA_WIDTH-1:0] r_fix;
    logic [DATA_WIDTH-1:0] z_rem;

    // One restoring step plus sign correction of the would-be final result
    always_comb begin
        r_shift = {r_reg, q_reg[DATA_WIDTH-1]};
        d_ext   = {1'b0, d_reg};
        fits    = (r_shift >= d_ext);
        r_step  = fits ? DATA_WIDTH'(r_shift - d_ext) : r_shift[DATA_WIDTH-1:0];
        q_step  = {q_reg[DATA_WIDTH-2:0], fits};
        q_fix   = q_neg ? -q_step : q_step;
        r_fix   = r_neg ? -r_step : r_step;
        // Divide-by-zero returns the original dividend, rebuilt from its magnitude.
        z_rem   = r_neg ? -q_reg : q_reg;
    end

    assign o_busy = (state != IDLE);

    // Controller: state, datapath registers and registered handshake/result outputs
    // NOTE: sequential state uses non-blocking assignments only; a later assignment
    // in the same block overrides an earlier one, which the grant path relies on.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            // NOTE: every register, datapath included, is reset so an aborted divide leaves no trace.
            state      <= IDLE;
            ptr        <= 1'b0;
            owner      <= 1'b0;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
            zero_div   <= 1'b0;
            count      <= '0;
            q_reg      <= '0;
            r_reg      <= '0;
            d_reg      <= '0;
            o_ack0     <= 1'b0;
            o_ack1     <= 1'b0;
            o_vld0     <= 1'b0;
            o_vld1     <= 1'b0;
            o_quot     <= '0;
            o_rem      <= '0;
            o_div_zero <= 1'b0;
        end else begin
            o_ack0 <= 1'b0;
            o_ack1 <= 1'b0;
            o_vld0 <= 1'b0;
            o_vld1 <= 1'b0;

            case (state)
                CALC: begin
                    q_reg <= q_step;
                    r_reg <= r_step;
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state      <= DONE;
                        o_quot     <= q_fix;
                        o_rem      <= r_fix;
                        o_div_zero <= 1'b0;
                        o_vld0     <= ~owner;
                        o_vld1     <= owner;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    if (zero_div) begin
                        o_quot     <= '0;
                        o_rem      <= z_rem;
                        o_div_zero <= 1'b1;
                        o_vld0     <= ~owner;
                        o_vld1     <= owner;
                    end
                end
                default: state <= IDLE;
            endcase

            // A grant from IDLE, or from DONE for back-to-back service
            if (grant) begin
                owner    <= winner;
                ptr      <= ~winner;
                o_ack0   <= ~winner;
                o_ack1   <= winner;
                q_reg    <= dvd_mag;
                r_reg    <= '0;
                d_reg    <= dvs_mag;
                q_neg    <= sel_dvd[DATA_WIDTH-1] ^ sel_dvs[DATA_WIDTH-1];
                r_neg    <= sel_dvd[DATA_WIDTH-1];
                zero_div <= (sel_dvs == '0);
                count    <= CW'(DATA_WIDTH);
                state    <= (sel_dvs == '0) ? DONE : CALC;
            end
        end
    end

endmodule

// File: tb/tb_lr_shared_divider_arbiter.sv
// Self-checking bench for lr_shared_divider_arbiter: directed scenarios plus
// randomized operands, checked against a signed-integer reference model.
module tb_lr_shared_divider_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [31:0] dvd0, dvs0, dvd1, dvs1;
    logic        ack0, ack1, vld0, vld1;
    logic [31:0] quot, rem;
    logic        div_zero, busy;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    lr_shared_divider_arbiter #(.DATA_WIDTH(32)) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_req0      (req0),
        .i_dividend0 (dvd0),
        .i_divisor0  (dvs0),
        .o_ack0      (ack0),
        .o_vld0      (vld0),
        .i_req1      (req1),
        .i_dividend1 (dvd1),
        .i_divisor1  (dvs1),
        .o_ack1      (ack1),
        .o_vld1      (vld1),
        .o_quot      (quot),
        .o_rem       (rem),
        .o_div_zero  (div_zero),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    // Reference: plain signed integer division, truncating toward zero
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic z);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sb == 0) begin
            q = 32'd0; r = a; z = 1'b1;
        end else begin
            q = 32'(sa / sb); r = 32'(sa % sb); z = 1'b0;
        end
    endtask

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'h8000_0000;
            1:       begin v = 32'($urandom_range(0, 20)); v = v - 32'd10; end
            2:       v = $urandom & 32'h0000_ffff;
            3:       begin v = $urandom & 32'h0000_ffff; v = -v; end
            default: v = $urandom;
        endcase
        return v;
    endfunction

    task automatic drive(input int who, input logic on, input logic [31:0] a, input logic [31:0] b);
        if (who == 0) begin req0 = on; dvd0 = a; dvs0 = b; end
        else          begin req1 = on; dvd1 = a; dvs1 = b; end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One request from `who`: returns ack/vld latency in cycles from the cycle req rose
    task automatic run_div(input int who, input logic [31:0] a, input logic [31:0] b, input bit mutate,
                           output int lat_ack, output int lat_vld,
                           output logic [31:0] q, output logic [31:0] r, output logic z,
                           output bit busy_ok, output bit cross_ok, output bit ok);
        int  c0;
        bit  got;
        ok = 1; busy_ok = 1; cross_ok = 1; lat_ack = -1; lat_vld = -1;
        q = 'x; r = 'x; z = 1'bx;
        @(negedge clk);
        c0 = cyc;
        drive(who, 1'b1, a, b);
        got = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ((who == 1) ? ack1 : ack0) begin got = 1; break; end
        end
        if (!got) begin ok = 0; drive(who, 1'b0, a, b); return; end
        lat_ack = cyc - c0;
        if (!busy) busy_ok = 0;
        if ((who == 1) ? ack0 : ack1) cross_ok = 0;
        drive(who, 1'b0, mutate ? 32'd9 : a, b);
        got = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ack0 || ack1) cross_ok = 0;
            if ((who == 1) ? vld0 : vld1) cross_ok = 0;
            if ((who == 1) ? vld1 : vld0) begin
                lat_vld = cyc - c0;
                q = quot; r = rem; z = div_zero;
                if (b != 0 && !busy) busy_ok = 0;
                got = 1;
                break;
            end
            if (!busy) busy_ok = 0;
        end
        if (!got) ok = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req0 = 0; req1 = 0; dvd0 = 0; dvs0 = 0; dvd1 = 0; dvs1 = 0;
        repeat (3) @(negedge clk);
        n_checks++; if ({ack0, ack1, vld0, vld1} !== 4'b0) $display("FAIL reset_pulses: got %b want 0000", {ack0, ack1, vld0, vld1}); else n_pass++;
        n_checks++; if (quot !== 32'd0) $display("FAIL reset_quot: got %h want 0", quot); else n_pass++;
        n_checks++; if (rem !== 32'd0) $display("FAIL reset_rem: got %h want 0", rem); else n_pass++;
        n_checks++; if (div_zero !== 1'b0) $display("FAIL reset_div_zero: got %b want 0", div_zero); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int la, lv; logic [31:0] q, r; logic z; bit bok, cok, ok;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL basic_idle_busy: got %b want 0", busy); else n_pass++;
        run_div(0, 32'd100, 32'd7, 0, la, lv, q, r, z, bok, cok, ok);
        n_checks++; if (!ok) $display("FAIL basic_timeout: handshake incomplete ack_lat=%0d vld_lat=%0d", la, lv); else n_pass++;
        n_checks++; if (la !== 1) $display("FAIL basic_ack_latency: got %0d want 1", la); else n_pass++;
        n_checks++; if (lv !== 33) $display("FAIL basic_vld_latency: got %0d want 33", lv); else n_pass++;
        n_checks++; if (q !== 32'd14) $display("FAIL basic_quot: got %0d want 14", $signed(q)); else n_pass++;
        n_checks++; if (r !== 32'd2) $display("FAIL basic_rem: got %0d want 2", $signed(r)); else n_pass++;
        n_checks++; if (z !== 1'b0) $display("FAIL basic_div_zero: got %b want 0", z); else n_pass++;
        n_checks++; if (!bok) $display("FAIL basic_busy_window: busy dropped between ack and vld, got 0 want 1"); else n_pass++;
        n_checks++; if (!cok) $display("FAIL basic_stray_pulse: got extra ack/vld want none"); else n_pass++;
    endtask

    task automatic test_signs();
        logic [31:0] a_tab [3] = '{-32'sd100, 32'd100, -32'sd100};
        logic [31:0] b_tab [3] = '{32'd7, -32'sd7, -32'sd7};
        int la, lv; logic [31:0] q, r, eq, er; logic z, ez; bit bok, cok, ok;
        for (int i = 0; i < 3; i++) begin
            run_div(1, a_tab[i], b_tab[i], 0, la, lv, q, r, z, bok, cok, ok);
            model(a_tab[i], b_tab[i], eq, er, ez);
            n_checks++; if (!ok || q !== eq) $display("FAIL signs_quot[%0d]: got %0d want %0d", i, $signed(q), $signed(eq)); else n_pass++;
            n_checks++; if (r !== er) $display("FAIL signs_rem[%0d]: got %0d want %0d", i, $signed(r), $signed(er)); else n_pass++;
        end
    endtask

    task automatic test_div_zero();
        int la, lv; logic [31:0] q, r; logic z; bit bok, cok, ok;
        run_div(0, 32'd55, 32'd0, 0, la, lv, q, r, z, bok, cok, ok);
        n_checks++; if (!ok || lv !== 2) $display("FAIL dz_vld_latency: got %0d want 2", lv); else n_pass++;
        n_checks++; if (q !== 32'd0) $display("FAIL dz_quot: got %0d want 0", $signed(q)); else n_pass++;
        n_checks++; if (r !== 32'd55) $display("FAIL dz_rem: got %0d want 55", $signed(r)); else n_pass++;
        n_checks++; if (z !== 1'b1) $display("FAIL dz_flag: got %b want 1", z); else n_pass++;
        run_div(1, 32'h8000_0000, 32'hffff_ffff, 0, la, lv, q, r, z, bok, cok, ok);
        n_checks++; if (!ok || q !== 32'h8000_0000) $display("FAIL minint_quot: got %h want 80000000", q); else n_pass++;
        n_checks++; if (r !== 32'd0 || z !== 1'b0) $display("FAIL minint_rem_flag: got %h/%b want 0/0", r, z); else n_pass++;
    endtask

    task automatic test_operand_stability();
        int la, lv; logic [31:0] q, r; logic z; bit bok, cok, ok;
        run_div(0, 32'd100, 32'd7, 1, la, lv, q, r, z, bok, cok, ok);
        n_checks++; if (!ok || q !== 32'd14 || r !== 32'd2) $display("FAIL stable_operands: got %0d rem %0d want 14 rem 2", $signed(q), $signed(r)); else n_pass++;
    endtask

    task automatic test_reset_abort();
        bit got; int vld_seen;
        @(negedge clk);
        drive(0, 1'b1, 32'd1000, 32'd3);
        got = 0;
        for (int i = 0; i < 10; i++) begin @(negedge clk); if (ack0) begin got = 1; break; end end
        n_checks++; if (!got) $display("FAIL abort_first_ack: got no ack want ack"); else n_pass++;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if ({ack0, ack1, vld0, vld1, div_zero, busy} !== 6'b0) $display("FAIL abort_flags: got %b want 000000", {ack0, ack1, vld0, vld1, div_zero, busy}); else n_pass++;
        n_checks++; if (quot !== 32'd0 || rem !== 32'd0) $display("FAIL abort_result: got %h/%h want 0/0", quot, rem); else n_pass++;
        vld_seen = 0;
        repeat (3) begin @(negedge clk); if (vld0 || vld1) vld_seen++; end
        rst = 1'b0;
        got = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (vld0 || vld1) vld_seen++;
            if (ack0) begin got = 1; break; end
        end
        n_checks++; if (vld_seen != 0) $display("FAIL abort_no_vld: got %0d vld pulses want 0", vld_seen); else n_pass++;
        drive(0, 1'b0, 32'd1000, 32'd3);
        if (got) begin
            got = 0;
            for (int i = 0; i < 100; i++) begin @(negedge clk); if (vld0) begin got = 1; break; end end
        end
        n_checks++; if (!got || quot !== 32'd333 || rem !== 32'd1) $display("FAIL abort_regrant: got %0d rem %0d (done=%0d) want 333 rem 1", $signed(quot), $signed(rem), got); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [31:0] ra [2], rb [2], eq, er;
        logic ez;
        int exp_who, who, last_vld;
        bit got;
        do_reset();
        for (int w = 0; w < 2; w++) begin
            ra[w] = rand_op();
            do rb[w] = rand_op(); while (rb[w] == 0);
        end
        @(negedge clk);
        drive(0, 1'b1, ra[0], rb[0]);
        drive(1, 1'b1, ra[1], rb[1]);
        exp_who = 0; last_vld = -1;
        for (int rnd = 0; rnd < 20; rnd++) begin
            got = 0;
            for (int i = 0; i < 100; i++) begin @(negedge clk); if (ack0 || ack1) begin got = 1; break; end end
            if (!got) begin
                n_checks++; $display("FAIL rr_ack_timeout[%0d]: got no ack want ack", rnd);
                break;
            end
            who = ack1 ? 1 : 0;
            n_checks++; if (who != exp_who) $display("FAIL rr_order[%0d]: got requester %0d want %0d", rnd, who, exp_who); else n_pass++;
            if (rnd > 0) begin
                n_checks++; if (cyc != last_vld + 1) $display("FAIL rr_back_to_back[%0d]: ack cycle %0d want %0d", rnd, cyc, last_vld + 1); else n_pass++;
            end
            drive(who, 1'b0, ra[who], rb[who]);
            got = 0;
            for (int i = 0; i < 100; i++) begin @(negedge clk); if ((who == 1) ? vld1 : vld0) begin got = 1; break; end end
            model(ra[who], rb[who], eq, er, ez);
            n_checks++; if (!got || quot !== eq || rem !== er) $display("FAIL rr_result[%0d]: got %h rem %h want %h rem %h", rnd, quot, rem, eq, er); else n_pass++;
            if (!got) break;
            last_vld = cyc;
            exp_who = 1 - exp_who;
            ra[who] = rand_op();
            do rb[who] = rand_op(); while (rb[who] == 0);
            drive(who, 1'b1, ra[who], rb[who]);
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL rr_idle_after: got busy %b want 0", busy); else n_pass++;
    endtask

    task automatic test_random();
        int la, lv, who; logic [31:0] a, b, q, r, eq, er; logic z, ez; bit bok, cok, ok;
        for (int i = 0; i < 24; i++) begin
            who = $urandom_range(0, 1);
            a = rand_op(); b = rand_op();
            run_div(who, a, b, 0, la, lv, q, r, z, bok, cok, ok);
            model(a, b, eq, er, ez);
            n_checks++;
            if (!ok || q !== eq || r !== er || z !== ez)
                $display("FAIL rand_result[%0d]: req%0d %h/%h got %h rem %h z %b want %h rem %h z %b", i, who, a, b, q, r, z, eq, er, ez);
            else n_pass++;
            n_checks++;
            if (la != 1 || lv != ((b == 0) ? 2 : 33) || !bok || !cok)
                $display("FAIL rand_timing[%0d]: got ack %0d vld %0d busy_ok %0d clean %0d want 1 %0d 1 1", i, la, lv, bok, cok, (b == 0) ? 2 : 33);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signs();
        test_div_zero();
        test_operand_stability();
        test_reset_abort();
        test_round_robin();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
